// File: rtl/wordcount_xfer_sequencer.sv
// wordcount_xfer_sequencer
// Job sequencer for the wordcount kernel. One kick splits the input region
// into chunks of at most C_CHUNK_BYTES and issues them to the AXI read master
// one at a time. It then waits for the counting engine to go idle and issues
// one write-back of the result region (placed directly after the input region)
// to the AXI write master.
//
// Ports:
//   ap_clk, areset                  clock, synchronous active-high reset
//   kick / busy                     job start pulse / job in progress
//   command, num_of_words,
//   global_memory_offset            job arguments, latched on an accepted kick
//   reader_ctrl_*                   read master control (start pulse, done, addr, size)
//   writer_ctrl_*                   write master control (start pulse, done, addr, size)
//   engine_idle, result_words       counting engine drained / result length
//   chunk_count                     read commands issued in the current job
module wordcount_xfer_sequencer #(
  parameter int unsigned C_ADDR_WIDTH  = 64,
  parameter int unsigned C_WORD_BYTES  = 64,
  parameter int unsigned C_CHUNK_BYTES = 4096
) (
  input  logic                    ap_clk,
  input  logic                    areset,
  input  logic                    kick,
  output logic                    busy,
  input  logic [31:0]             command,
  input  logic [31:0]             num_of_words,
  input  logic [63:0]             global_memory_offset,
  output logic                    reader_ctrl_start,
  input  logic                    reader_ctrl_done,
  output logic [C_ADDR_WIDTH-1:0] reader_ctrl_addr_offset,
  output logic [63:0]             reader_ctrl_xfer_size_in_bytes,
  output logic                    writer_ctrl_start,
  input  logic                    writer_ctrl_done,
  output logic [C_ADDR_WIDTH-1:0] writer_ctrl_addr_offset,
  output logic [63:0]             writer_ctrl_xfer_size_in_bytes,
  input  logic                    engine_idle,
  input  logic [31:0]             result_words,
  output logic [31:0]             chunk_count
);

  // Byte counts are word counts scaled by the word size; this width never overflows.
  localparam int unsigned BYTES_W = 32 + $clog2(C_WORD_BYTES);
  localparam int unsigned SIZE_W  = 64;
  localparam logic [BYTES_W-1:0] CHUNK_BYTES = BYTES_W'(C_CHUNK_BYTES);
  localparam logic [BYTES_W-1:0] WORD_BYTES  = BYTES_W'(C_WORD_BYTES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ISSUE,
    S_RD_WAIT,
    S_DRAIN,
    S_WR_ISSUE,
    S_WR_WAIT,
    S_DONE
  } state_e;

  state_e                  state_q, state_d;
  logic                    busy_q, busy_d;
  logic                    rd_start_q, rd_start_d;
  logic [C_ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [SIZE_W-1:0]       rd_size_q, rd_size_d;
  logic                    wr_start_q, wr_start_d;
  logic [C_ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [SIZE_W-1:0]       wr_size_q, wr_size_d;
  logic [31:0]             chunk_count_q, chunk_count_d;
  logic                    cmd_wr_q, cmd_wr_d;
  logic [C_ADDR_WIDTH-1:0] offset_q, offset_d;
  logic [BYTES_W-1:0]      total_q, total_d;
  logic [BYTES_W-1:0]      remaining_q, remaining_d;

  logic [BYTES_W-1:0]      total_c;
  logic [BYTES_W-1:0]      rem_after_c;

  // Only the two low command bits carry meaning.
  logic unused_cmd_bits;
  assign unused_cmd_bits = ^command[31:2];

  // Size of the next chunk: the remainder, capped at one chunk.
  function automatic logic [BYTES_W-1:0] chunk_of(input logic [BYTES_W-1:0] rem);
    return (rem < CHUNK_BYTES) ? rem : CHUNK_BYTES;
  endfunction

  assign total_c     = BYTES_W'(num_of_words) * WORD_BYTES;
  assign rem_after_c = remaining_q - BYTES_W'(rd_size_q);

  // State and datapath registers.
  always_ff @(posedge ap_clk) begin
    if (areset) begin
      state_q       <= S_IDLE;
      busy_q        <= 1'b0;
      rd_start_q    <= 1'b0;
      rd_addr_q     <= '0;
      rd_size_q     <= '0;
      wr_start_q    <= 1'b0;
      wr_addr_q     <= '0;
      wr_size_q     <= '0;
      chunk_count_q <= '0;
      cmd_wr_q      <= 1'b0;
      offset_q      <= '0;
      total_q       <= '0;
      remaining_q   <= '0;
    end else begin
      state_q       <= state_d;
      busy_q        <= busy_d;
      rd_start_q    <= rd_start_d;
      rd_addr_q     <= rd_addr_d;
      rd_size_q     <= rd_size_d;
      wr_start_q    <= wr_start_d;
      wr_addr_q     <= wr_addr_d;
      wr_size_q     <= wr_size_d;
      chunk_count_q <= chunk_count_d;
      cmd_wr_q      <= cmd_wr_d;
      offset_q      <= offset_d;
      total_q       <= total_d;
      remaining_q   <= remaining_d;
    end
  end

  // Next state; control outputs are loaded on the transition into an ISSUE
  // state so the start pulse and its addr/size appear in the same cycle.
  always_comb begin
    state_d       = state_q;
    rd_start_d    = 1'b0;
    rd_addr_d     = rd_addr_q;
    rd_size_d     = rd_size_q;
    wr_start_d    = 1'b0;
    wr_addr_d     = wr_addr_q;
    wr_size_d     = wr_size_q;
    chunk_count_d = chunk_count_q;
    cmd_wr_d      = cmd_wr_q;
    offset_d      = offset_q;
    total_d       = total_q;
    remaining_d   = remaining_q;

    unique case (state_q)
      S_IDLE: begin
        if (kick) begin
          cmd_wr_d      = command[1];
          offset_d      = C_ADDR_WIDTH'(global_memory_offset);
          total_d       = total_c;
          remaining_d   = total_c;
          chunk_count_d = 32'd0;
          if (command[0] && (total_c != '0)) begin
            state_d       = S_RD_ISSUE;
            rd_start_d    = 1'b1;
            rd_addr_d     = C_ADDR_WIDTH'(global_memory_offset);
            rd_size_d     = SIZE_W'(chunk_of(total_c));
            chunk_count_d = 32'd1;
          end else begin
            state_d = S_DRAIN;
          end
        end
      end
      S_RD_ISSUE: state_d = S_RD_WAIT;
      S_RD_WAIT: begin
        if (reader_ctrl_done) begin
          remaining_d = rem_after_c;
          if (rem_after_c != '0) begin
            state_d       = S_RD_ISSUE;
            rd_start_d    = 1'b1;
            rd_addr_d     = rd_addr_q + C_ADDR_WIDTH'(rd_size_q);
            rd_size_d     = SIZE_W'(chunk_of(rem_after_c));
            chunk_count_d = chunk_count_q + 32'd1;
          end else begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (engine_idle) begin
          if (cmd_wr_q && (result_words != 32'd0)) begin
            state_d    = S_WR_ISSUE;
            wr_start_d = 1'b1;
            wr_addr_d  = offset_q + C_ADDR_WIDTH'(total_q);
            wr_size_d  = SIZE_W'(BYTES_W'(result_words) * WORD_BYTES);
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_WR_ISSUE: state_d = S_WR_WAIT;
      S_WR_WAIT: begin
        if (writer_ctrl_done) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  assign busy                           = busy_q;
  assign reader_ctrl_start              = rd_start_q;
  assign reader_ctrl_addr_offset        = rd_addr_q;
  assign reader_ctrl_xfer_size_in_bytes = rd_size_q;
  assign writer_ctrl_start              = wr_start_q;
  assign writer_ctrl_addr_offset        = wr_addr_q;
  assign writer_ctrl_xfer_size_in_bytes = wr_size_q;
  assign chunk_count                    = chunk_count_q;

endmodule

// File: tb/tb_wordcount_xfer_sequencer.sv
// Self-checking bench for wordcount_xfer_sequencer. The driver runs jobs
// cycle by cycle and checks handshake timing; a reference model pushes the
// expected read/write commands into queues that a separate monitor pops
// whenever the DUT pulses a start.
`timescale 1ns/1ps
module tb_wordcount_xfer_sequencer;

  logic        ap_clk = 1'b0;
  logic        areset;
  logic        kick;
  logic        busy;
  logic [31:0] command;
  logic [31:0] num_of_words;
  logic [63:0] global_memory_offset;
  logic        reader_ctrl_start;
  logic        reader_ctrl_done;
  logic [63:0] reader_ctrl_addr_offset;
  logic [63:0] reader_ctrl_xfer_size_in_bytes;
  logic        writer_ctrl_start;
  logic        writer_ctrl_done;
  logic [63:0] writer_ctrl_addr_offset;
  logic [63:0] writer_ctrl_xfer_size_in_bytes;
  logic        engine_idle;
  logic [31:0] result_words;
  logic [31:0] chunk_count;

  always #5 ap_clk = ~ap_clk;

  wordcount_xfer_sequencer dut (
    .ap_clk                         (ap_clk),
    .areset                         (areset),
    .kick                           (kick),
    .busy                           (busy),
    .command                        (command),
    .num_of_words                   (num_of_words),
    .global_memory_offset           (global_memory_offset),
    .reader_ctrl_start              (reader_ctrl_start),
    .reader_ctrl_done               (reader_ctrl_done),
    .reader_ctrl_addr_offset        (reader_ctrl_addr_offset),
    .reader_ctrl_xfer_size_in_bytes (reader_ctrl_xfer_size_in_bytes),
    .writer_ctrl_start              (writer_ctrl_start),
    .writer_ctrl_done               (writer_ctrl_done),
    .writer_ctrl_addr_offset        (writer_ctrl_addr_offset),
    .writer_ctrl_xfer_size_in_bytes (writer_ctrl_xfer_size_in_bytes),
    .engine_idle                    (engine_idle),
    .result_words                   (result_words),
    .chunk_count                    (chunk_count)
  );

  typedef struct packed {
    logic [63:0] addr;
    logic [63:0] size;
    logic [31:0] cnt;
  } xfer_t;

  xfer_t       rd_q[$];
  xfer_t       wr_q[$];
  xfer_t       rx;
  xfer_t       wx;
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  // Reference model: chunk list and write-back from plain byte arithmetic.
  task automatic model_job(input logic [1:0] cmd, input logic [31:0] nw, input logic [63:0] off,
                           input logic [31:0] rw, output int n_rd, output bit do_wr);
    logic [63:0] total, rem, a, sz;
    xfer_t x;
    total = 64'(nw) * 64'd64;
    n_rd  = 0;
    if (cmd[0] && total != 64'd0) begin
      rem = total;
      a   = off;
      while (rem != 64'd0) begin
        sz = (rem > 64'd4096) ? 64'd4096 : rem;
        n_rd++;
        x.addr = a;
        x.size = sz;
        x.cnt  = 32'(n_rd);
        rd_q.push_back(x);
        a   = a + sz;
        rem = rem - sz;
      end
    end
    do_wr = cmd[1] && (rw != 32'd0);
    if (do_wr) begin
      x.addr = off + total;
      x.size = 64'(rw) * 64'd64;
      x.cnt  = 32'(n_rd);
      wr_q.push_back(x);
    end
  endtask

  // Monitor: every start pulse must match the next expected command.
  initial begin
    forever begin
      @(negedge ap_clk);
      if (reader_ctrl_start) begin
        if (rd_q.size() == 0) begin
          chk("rd_unexpected_start", 64'(reader_ctrl_start), 64'd0);
        end else begin
          rx = rd_q.pop_front();
          chk("rd_addr", reader_ctrl_addr_offset, rx.addr);
          chk("rd_size", reader_ctrl_xfer_size_in_bytes, rx.size);
          chk("rd_chunk_count", 64'(chunk_count), 64'(rx.cnt));
        end
      end
      if (writer_ctrl_start) begin
        if (wr_q.size() == 0) begin
          chk("wr_unexpected_start", 64'(writer_ctrl_start), 64'd0);
        end else begin
          wx = wr_q.pop_front();
          chk("wr_addr", writer_ctrl_addr_offset, wx.addr);
          chk("wr_size", writer_ctrl_xfer_size_in_bytes, wx.size);
          chk("wr_chunk_count", 64'(chunk_count), 64'(wx.cnt));
        end
      end
    end
  end

  // One full job. spur adds stray done pulses in IDLE/DRAIN and a kick with
  // garbage arguments in RD_WAIT; idle_pre holds engine_idle high throughout.
  task automatic run_job(input logic [1:0] cmd, input logic [31:0] nw, input logic [63:0] off,
                         input logic [31:0] rw, input bit spur, input bit idle_pre);
    int n_rd;
    bit do_wr;
    int d;
    model_job(cmd, nw, off, rw, n_rd, do_wr);
    engine_idle  = idle_pre;
    result_words = idle_pre ? rw : $urandom;
    if (spur) begin
      reader_ctrl_done = 1'b1;
      writer_ctrl_done = 1'b1;
      tick();
      reader_ctrl_done = 1'b0;
      writer_ctrl_done = 1'b0;
      chk("idle_spurious_busy", 64'(busy), 64'd0);
    end
    command              = {30'($urandom), cmd};
    num_of_words         = nw;
    global_memory_offset = off;
    kick = 1'b1;
    tick();
    kick = 1'b0;
    chk("busy_after_kick", 64'(busy), 64'd1);
    for (int r = 0; r < n_rd; r++) begin
      chk("rd_start_pulse", 64'(reader_ctrl_start), 64'd1);
      tick();
      chk("rd_start_one_cycle", 64'(reader_ctrl_start), 64'd0);
      d = spur ? 1 + int'($urandom_range(2)) : int'($urandom_range(3));
      for (int i = 0; i < d; i++) begin
        if (spur && i == 0) begin
          kick                 = 1'b1;
          command              = $urandom;
          num_of_words         = $urandom;
          global_memory_offset = {$urandom, $urandom};
        end
        tick();
        kick = 1'b0;
      end
      reader_ctrl_done = 1'b1;
      tick();
      reader_ctrl_done = 1'b0;
    end
    if (n_rd > 0) chk("drain_no_rd_start", 64'(reader_ctrl_start), 64'd0);
    chk("busy_in_drain", 64'(busy), 64'd1);
    d = idle_pre ? 0 : (spur ? 1 + int'($urandom_range(2)) : int'($urandom_range(3)));
    for (int i = 0; i < d; i++) begin
      if (spur && i == 0) reader_ctrl_done = 1'b1;
      tick();
      reader_ctrl_done = 1'b0;
    end
    engine_idle  = 1'b1;
    result_words = rw;
    tick();
    if (do_wr) begin
      chk("wr_start_pulse", 64'(writer_ctrl_start), 64'd1);
      tick();
      chk("wr_start_one_cycle", 64'(writer_ctrl_start), 64'd0);
      d = int'($urandom_range(3));
      for (int i = 0; i < d; i++) tick();
      writer_ctrl_done = 1'b1;
      tick();
      writer_ctrl_done = 1'b0;
    end
    chk("done_no_wr_start", 64'(writer_ctrl_start), 64'd0);
    chk("busy_in_done", 64'(busy), 64'd1);
    tick();
    chk("busy_low_after_done", 64'(busy), 64'd0);
    chk("chunk_count_final", 64'(chunk_count), 64'(n_rd));
    chk("rd_q_drained", 64'(rd_q.size()), 64'd0);
    chk("wr_q_drained", 64'(wr_q.size()), 64'd0);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_rd_start"}, 64'(reader_ctrl_start), 64'd0);
    chk({tag, "_rd_addr"}, reader_ctrl_addr_offset, 64'd0);
    chk({tag, "_rd_size"}, reader_ctrl_xfer_size_in_bytes, 64'd0);
    chk({tag, "_wr_start"}, 64'(writer_ctrl_start), 64'd0);
    chk({tag, "_wr_addr"}, writer_ctrl_addr_offset, 64'd0);
    chk({tag, "_wr_size"}, writer_ctrl_xfer_size_in_bytes, 64'd0);
    chk({tag, "_chunk_count"}, 64'(chunk_count), 64'd0);
  endtask

  // Reset while waiting on the first chunk of a two-chunk job.
  task automatic reset_mid_job();
    xfer_t x;
    x.addr = 64'h5000;
    x.size = 64'd4096;
    x.cnt  = 32'd1;
    rd_q.push_back(x);
    engine_idle          = 1'b0;
    command              = 32'd3;
    num_of_words         = 32'd128;
    global_memory_offset = 64'h5000;
    kick = 1'b1;
    tick();
    kick = 1'b0;
    tick();
    areset = 1'b1;
    tick();
    areset = 1'b0;
    check_reset_values("mid_job_reset");
    chk("mid_job_rd_q", 64'(rd_q.size()), 64'd0);
    tick();
    chk("post_reset_idle_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    logic [1:0]  rc;
    logic [31:0] rn;
    logic [31:0] rr;
    areset               = 1'b1;
    kick                 = 1'b0;
    command              = '0;
    num_of_words         = '0;
    global_memory_offset = '0;
    reader_ctrl_done     = 1'b0;
    writer_ctrl_done     = 1'b0;
    engine_idle          = 1'b0;
    result_words         = '0;
    tick();
    tick();
    check_reset_values("reset");
    areset = 1'b0;
    tick();

    run_job(2'd3, 32'd128, 64'h1000, 32'd2, 1'b0, 1'b0);
    run_job(2'd1, 32'd70, 64'h0000_0001_2345_0000, 32'd5, 1'b0, 1'b0);
    run_job(2'd3, 32'd0, 64'h8000, 32'd0, 1'b0, 1'b1);
    run_job(2'd3, 32'd200, 64'h4_0000, 32'd3, 1'b1, 1'b0);
    run_job(2'd3, 32'd128, 64'hFFFF_FFFF_FFFF_F000, 32'd1, 1'b0, 1'b0);
    run_job(2'd2, 32'd64, 64'h9000, 32'd4, 1'b0, 1'b1);
    reset_mid_job();
    run_job(2'd3, 32'd100, 64'h7777_0000, 32'd2, 1'b0, 1'b0);

    for (int j = 0; j < 40; j++) begin
      rc = 2'($urandom_range(3));
      rn = ($urandom_range(7) == 0) ? 32'd0 : 32'($urandom_range(1, 600));
      rr = 32'($urandom_range(4));
      run_job(rc, rn, {$urandom, $urandom}, rr, ($urandom_range(1) == 1), ($urandom_range(3) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
